// File: rtl/mem_wb_hilo_pkg.sv
// Shared constants for the MEM/WB write-back slice: default widths, bubble address and enable levels.
// The HI/LO register and the top module both import this package.
package mem_wb_hilo_pkg;
   localparam int  REG_BUS_W     = 32;
   localparam int  REG_ADDR_W    = 5;
   localparam int  NOP_REG_ADDR  = 0;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
endpackage

// File: rtl/mem_wb_hilo_hilo_reg.sv
// Architectural HI/LO register pair, loaded from the MEM/WB latch when we is high.
import mem_wb_hilo_pkg::*;

module hilo_reg #(
   parameter int DATA_W = REG_BUS_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [DATA_W-1:0] hi_i,
   input  logic [DATA_W-1:0] lo_i,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_o <= '0;
         lo_o <= '0;
      end else if (we == WRITE_ENABLE) begin
         hi_o <= hi_i;
         lo_o <= lo_i;
      end
   end

endmodule

// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline latch with stall/flush priority, regfile write port, and HI/LO ownership
// with a read port for EX that bypasses a pending WB-stage HI/LO write.
import mem_wb_hilo_pkg::*;

module mem_wb_hilo #(
   parameter int DATA_W   = REG_BUS_W,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int NOP_ADDR = NOP_REG_ADDR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_mem,
   input  logic              stall_wb,
   input  logic              flush,
   input  logic [ADDR_W-1:0] mem_wd,
   input  logic              mem_wreg,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_whilo,
   input  logic [DATA_W-1:0] mem_hi,
   input  logic [DATA_W-1:0] mem_lo,
   output logic [ADDR_W-1:0] wb_wd,
   output logic              wb_wreg,
   output logic [DATA_W-1:0] wb_wdata,
   output logic              wb_whilo,
   output logic [DATA_W-1:0] wb_hi,
   output logic [DATA_W-1:0] wb_lo,
   output logic [DATA_W-1:0] hi_rd,
   output logic [DATA_W-1:0] lo_rd
);

   localparam logic [ADDR_W-1:0] BUBBLE_ADDR = ADDR_W'(NOP_ADDR);

   logic              hold;
   logic              hilo_we;
   logic [DATA_W-1:0] hi_arch;
   logic [DATA_W-1:0] lo_arch;

   // Hold only when both stages stall and no flush overrides; a held HI/LO write waits for release.
   assign hold    = stall_mem && stall_wb && !flush;
   assign hilo_we = wb_whilo && !hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush || (stall_mem && !stall_wb)) begin
         wb_wd    <= BUBBLE_ADDR;
         wb_wreg  <= WRITE_DISABLE;
         wb_wdata <= '0;
         wb_whilo <= WRITE_DISABLE;
         wb_hi    <= '0;
         wb_lo    <= '0;
      end else if (!stall_mem) begin
         wb_wd    <= mem_wd;
         wb_wreg  <= mem_wreg;
         wb_wdata <= mem_wdata;
         wb_whilo <= mem_whilo;
         wb_hi    <= mem_hi;
         wb_lo    <= mem_lo;
      end
   end

   hilo_reg #(
      .DATA_W (DATA_W)
   ) u_hilo_reg (
      .clk  (clk),
      .rst  (rst),
      .we   (hilo_we),
      .hi_i (wb_hi),
      .lo_i (wb_lo),
      .hi_o (hi_arch),
      .lo_o (lo_arch)
   );

   assign hi_rd = wb_whilo ? wb_hi : hi_arch;
   assign lo_rd = wb_whilo ? wb_lo : lo_arch;

   // ctrl never stalls WB while MEM runs; if it does, the latch still captures.
   illegal_stall_combo: assert property (@(posedge clk) disable iff (rst) !(stall_wb && !stall_mem));

endmodule
